// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters. Requests use
// valid/ready handshakes and are arbitrated round-robin. The granted
// operands are registered onto the ALU inputs. The ALU result is captured
// one cycle later. It is then returned, together with a zero flag, on the
// owner's response channel. The block holds that response until the owner
// accepts it.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   reqN_valid / reqN_ready   request handshake for requester N (0,1)
//   reqN_a, reqN_b, reqN_f    operands and function code for requester N
//   rspN_valid / rspN_ready   response handshake for requester N
//   rspN_y, rspN_zero         result and (result == 0) for requester N
//   alu_a, alu_b, alu_f       registered operands driven into the ALU
//   alu_y                     combinational ALU result
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int FW    = 3
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [FW-1:0]    req0_f,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [FW-1:0]    req1_f,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_y,
    output logic             rsp0_zero,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_y,
    output logic             rsp1_zero,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [FW-1:0]    alu_f,
    input  logic [WIDTH-1:0] alu_y
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q;
    logic             owner_q;
    logic             grant;
    logic             accept;
    logic             owner_rsp_ready;

    logic [WIDTH-1:0] alu_a_q, alu_b_q;
    logic [FW-1:0]    alu_f_q;
    logic [WIDTH-1:0] rsp0_y_q, rsp1_y_q;
    logic             rsp0_zero_q, rsp1_zero_q;

    // On a tie the requester that did not win last time is chosen. Otherwise
    // the single valid requester is chosen.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end
    end

    assign accept          = (state_q == IDLE) && (req0_valid || req1_valid);
    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    // Qualifying with reset_n keeps ready low while reset is held. The FSM
    // already sits in IDLE during reset.
    assign req0_ready = reset_n && (state_q == IDLE) && req0_valid && !grant;
    assign req1_ready = reset_n && (state_q == IDLE) && req1_valid &&  grant;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (owner_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_f_q      <= '0;
            rsp0_y_q     <= '0;
            rsp1_y_q     <= '0;
            rsp0_zero_q  <= 1'b0;
            rsp1_zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q      <= grant;
                last_grant_q <= grant;
                alu_a_q      <= grant ? req1_a : req0_a;
                alu_b_q      <= grant ? req1_b : req0_b;
                alu_f_q      <= grant ? req1_f : req0_f;
            end
            // Only the owner's result register is written. The other channel
            // keeps its last response.
            if (state_q == EXEC) begin
                if (owner_q) begin
                    rsp1_y_q    <= alu_y;
                    rsp1_zero_q <= (alu_y == '0);
                end else begin
                    rsp0_y_q    <= alu_y;
                    rsp0_zero_q <= (alu_y == '0);
                end
            end
        end
    end

    assign rsp0_valid = (state_q == RESP) && !owner_q;
    assign rsp1_valid = (state_q == RESP) &&  owner_q;
    assign rsp0_y     = rsp0_y_q;
    assign rsp1_y     = rsp1_y_q;
    assign rsp0_zero  = rsp0_zero_q;
    assign rsp1_zero  = rsp1_zero_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_f      = alu_f_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. A small behavioural ALU stands in for the
// real ALU instance. Expected results are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_f, req1_f;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_y, rsp1_y;
    logic        rsp0_zero, rsp1_zero;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [2:0]  alu_f;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .FW(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_f     (req0_f),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_f     (req1_f),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_y     (rsp0_y),
        .rsp0_zero  (rsp0_zero),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_y     (rsp1_y),
        .rsp1_zero  (rsp1_zero),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_f      (alu_f),
        .alu_y      (alu_y)
    );

    // Behavioural ALU: F[2] inverts B and carries in, F[1:0] = AND/OR/ADD/SLT.
    logic [31:0] bb, sum;
    always_comb begin
        bb  = alu_f[2] ? ~alu_b : alu_b;
        sum = alu_a + bb + {31'd0, alu_f[2]};
        case (alu_f[1:0])
            2'b00:   alu_y = alu_a & bb;
            2'b01:   alu_y = alu_a | bb;
            2'b10:   alu_y = sum;
            default: alu_y = {31'd0, sum[31]};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on a single requester with immediate response.
    task automatic op(input int port, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] f, input logic [31:0] ey, input logic ez);
        if (port == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_f = f;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_f = f;
        end
        #1;
        chk("op_ready_own",   port == 0 ? req0_ready : req1_ready, 1);
        chk("op_ready_other", port == 0 ? req1_ready : req0_ready, 0);
        tick();                                   // T+1: EXEC
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("op_alu_a", alu_a, a);
        chk("op_alu_f", {29'd0, alu_f}, {29'd0, f});
        chk("op_exec_valid", {30'd0, rsp1_valid, rsp0_valid}, 0);
        tick();                                   // T+2: RESP
        chk("op_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, port == 0 ? 32'd1 : 32'd2);
        chk("op_rsp_y",     port == 0 ? rsp0_y : rsp1_y, ey);
        chk("op_rsp_zero",  port == 0 ? rsp0_zero : rsp1_zero, {31'd0, ez});
        if (port == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        tick();                                   // T+3: IDLE
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        chk("op_rsp_drop", {30'd0, rsp1_valid, rsp0_valid}, 0);
        chk("op_y_hold",   port == 0 ? rsp0_y : rsp1_y, ey);
    endtask

    initial begin
        reset_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 0; req0_b = 0; req0_f = 0;
        req1_a = 0; req1_b = 0; req1_f = 0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        tick(); tick();

        // Reset state, with both requesters valid.
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_rsp_valid",  {30'd0, rsp1_valid, rsp0_valid}, 0);
        chk("rst_alu_a",      alu_a, 0);
        chk("rst_alu_f",      {29'd0, alu_f}, 0);
        chk("rst_rsp0_y",     rsp0_y, 0);
        chk("rst_rsp1_zero",  rsp1_zero, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset_n = 1'b1;
        tick();

        // Single add on requester 0, then subtract / SLT on requester 1.
        op(0, 32'd5, 32'd3, 3'b010, 32'd8, 1'b0);
        chk("add_rsp1_y_untouched", rsp1_y, 0);
        op(1, 32'd3, 32'd5, 3'b110, 32'hFFFF_FFFE, 1'b0);
        op(1, 32'd3, 32'd5, 3'b111, 32'd1, 1'b0);
        op(1, 32'd7, 32'd7, 3'b110, 32'd0, 1'b1);

        // Round-robin with both valid continuously, after a fresh reset.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_f = 3'b010;
        req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd2; req1_f = 3'b001;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_ready", {30'd0, req1_ready, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            chk("rr_exec_ready", {30'd0, req1_ready, req0_ready}, 0);
            tick();
            chk("rr_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_rsp_y", (i % 2 == 0) ? rsp0_y : rsp1_y, (i % 2 == 0) ? 32'd2 : 32'd6);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        tick();

        // Backpressure on rsp0 with req1 waiting; a non-owner ready pulse.
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_f = 3'b010;
        #1;
        chk("bp_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        tick();                                   // RESP for requester 0
        req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd2; req1_f = 3'b001;
        for (int i = 0; i < 5; i++) begin
            rsp1_ready = (i == 2);
            #1;
            chk("bp_req1_ready", req1_ready, 0);
            chk("bp_rsp0_valid", rsp0_valid, 1);
            chk("bp_rsp0_y",     rsp0_y, 32'd8);
            tick();
        end
        rsp1_ready = 1'b0;
        chk("bp_nonowner_hold", rsp0_valid, 1);
        rsp0_ready = 1'b1;
        tick();                                   // back to IDLE
        rsp0_ready = 1'b0;
        #1;
        chk("bp_rsp0_drop",  rsp0_valid, 0);
        chk("bp_req1_accept", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("bp_rsp1_valid", rsp1_valid, 1);
        chk("bp_rsp1_y",     rsp1_y, 32'd6);
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;

        // Reset asserted during EXEC.
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd1; req0_f = 3'b010;
        #1;
        chk("mid_req0_ready", req0_ready, 1);
        tick();                                   // EXEC
        chk("mid_alu_a_exec", alu_a, 32'd9);
        reset_n = 1'b0;
        #1;
        chk("mid_alu_a",      alu_a, 0);
        chk("mid_alu_b",      alu_b, 0);
        chk("mid_ready",      {30'd0, req1_ready, req0_ready}, 0);
        chk("mid_rsp0_y",     rsp0_y, 0);
        chk("mid_rsp1_y",     rsp1_y, 0);
        req0_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 0);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("mid_tie_grant0", {30'd0, req1_ready, req0_ready}, 32'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit combinational ALU between two requesters, such as the datapath sequencer and a debug/test port, using valid/ready handshakes. Arbitration is round-robin. The block registers the granted operands into the ALU inputs, captures the ALU result one cycle later, and returns it with a zero flag on the granted requester's response channel. The block sits between the requesters and the ALU instance; the ALU itself is unmodified.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- FW, 3, function-code width; F[2] selects inverted B / subtract, F[1:0] selects AND/OR/ADD/SLT.

Ports (n = 0,1 per requester):
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- reqn_valid  in  1  requester n presents an operation.
- reqn_ready  out  1  operation accepted this cycle when valid&ready.
- reqn_a, reqn_b  in  WIDTH  operands.
- reqn_f  in  FW  ALU function code, passed through unmodified.
- rspn_valid  out  1  result available for requester n.
- rspn_ready  in  1  requester n consumes the result.
- rspn_y  out  WIDTH  result.
- rspn_zero  out  1  result == 0.
- alu_a, alu_b  out  WIDTH  registered ALU operands.
- alu_f  out  FW  registered ALU function.
- alu_y  in  WIDTH  ALU combinational result.

## Operation
- FSM states and transitions:
  - IDLE: go to EXEC on any accepted request.
  - EXEC: always go to RESP after 1 cycle.
  - RESP: go to IDLE when the owner's rspn_ready is high; otherwise hold.
- Grant in IDLE:
  - Only one requester valid: that requester wins.
  - Both valid: the requester not equal to last_grant wins.
- reqn_ready = (state == IDLE) && (grant == n). It may depend combinationally on both valids. It is never high outside IDLE.
- On accept:
  - alu_a/alu_b/alu_f <= granted operands.
  - owner <= n; last_grant <= n.
- EXEC: capture alu_y into the result register and compute zero = (alu_y == 0).
- RESP:
  - rspn_valid is high only for the owner. rspn_y and rspn_zero are valid only while rspn_valid is high; otherwise they hold their last value.
  - rspn_ready from the non-owner is ignored.
- alu_a/b/f hold their values after an operation (no toggling when idle).
- F codes are not checked; all 8 codes are forwarded. Width and arithmetic are defined by the ALU (the SLT result is 0 or 1, zero-extended).

## Timing
- Reset values (asynchronous assert):
  - State = IDLE, last_grant = 1, so requester 0 wins the first tie.
  - All rsp*_valid = 0; rsp*_y = 0; rsp*_zero = 0.
  - alu_a, alu_b, alu_f = 0; req*_ready = 0 while reset_n is low.
- Cycle map, with accept in cycle T:
  - T: accept in IDLE.
  - T+1: EXEC.
  - T+2: rspn_valid = 1.
- Latency is accept → rsp_valid = 2 cycles.
- If rspn_ready is high in the first RESP cycle, IDLE is reached at T+3 and the next accept can occur at T+3. Minimum issue interval is 3 cycles.
- Backpressure: RESP holds indefinitely with y/zero stable. Requests arriving meanwhile wait with ready=0 and must hold valid and payload until accepted.
- Simultaneous valid: exactly one ready, never both.
- Reset mid-operation (EXEC or RESP): the operation is dropped, no response is issued, and the block returns to the reset values above.

## Test plan
- Single add: req0 a=5, b=3, f=3'b010 → rsp0_valid at T+2, y=8, zero=0; rsp1_valid stays 0.
- Subtract and SLT on req1:
  - a=3, b=5, f=3'b110 → y=32'hFFFFFFFE, zero=0.
  - Then f=3'b111 → y=1.
  - a=7, b=7, f=3'b110 → y=0, zero=1.
- Tie and round-robin: after reset, both valid every cycle (req0 f=010 1+1, req1 f=001 4|2) → grants alternate 0,1,0,1, with results 2 and 6 on the correct channels. req*_ready is never high in the same cycle for both requesters.
- Backpressure: hold rsp0_ready=0 for 5 cycles while req1_valid=1 → req1_ready stays 0, rsp0_y stays stable. Drop to IDLE one cycle after rsp0_ready=1, then req1 is accepted.
- Non-owner ready ignored: pulse rsp1_ready while rsp0 is pending → no state change.
- Reset mid-EXEC: assert reset_n=0 in EXEC → all outputs at reset values immediately and no response after release. The next tie grants requester 0.
